// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM encodings, funct3 width codes
// and the sign/zero extension helper used by the lane aligner.
package lsu_pkg;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_RESP = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int LSU_BE_W = 4;

  // Extends a byte (low 8 bits of v) or a halfword to 32 bits.
  function automatic logic [31:0] lsu_extend(input logic [15:0] v,
                                             input logic is_half,
                                             input logic is_unsigned);
    logic [31:0] res;
    if (is_half)
      res = is_unsigned ? {16'h0000, v} : {{16{v[15]}}, v};
    else
      res = is_unsigned ? {24'h000000, v[7:0]} : {{24{v[7]}}, v[7:0]};
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment/illegal-width detection, store
// byte-enable and data replication, and load byte/half extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic                i_wr,
  input  logic [2:0]          i_funct3,
  input  logic [1:0]          i_addr_lo,
  input  logic [31:0]         i_wdata,
  input  logic [31:0]         i_rdata,
  output logic                o_misalign,
  output logic [LSU_BE_W-1:0] o_be,
  output logic [31:0]         o_wdata,
  output logic [31:0]         o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Unsigned widths are load-only, so a store using them is illegal.
  always_comb begin
    o_misalign = 1'b0;
    case (i_funct3)
      LSU_B:   o_misalign = 1'b0;
      LSU_H:   o_misalign = i_addr_lo[0];
      LSU_W:   o_misalign = |i_addr_lo;
      LSU_BU:  o_misalign = i_wr;
      LSU_HU:  o_misalign = i_wr | i_addr_lo[0];
      default: o_misalign = 1'b1;
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    if (i_wr) begin
      case (i_funct3)
        LSU_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        LSU_H: begin
          o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_funct3)
      LSU_B:   o_rdata = lsu_extend({8'h00, w_byte}, 1'b0, 1'b0);
      LSU_BU:  o_rdata = lsu_extend({8'h00, w_byte}, 1'b0, 1'b1);
      LSU_H:   o_rdata = lsu_extend(w_half, 1'b1, 1'b0);
      LSU_HU:  o_rdata = lsu_extend(w_half, 1'b1, 1'b1);
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: single-outstanding req/gnt/rvalid bus master
// that stalls upstream while an access is in flight.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ex_valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  logic [1:0]  r_state;
  logic        r_wr;
  logic        r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_memop;
  logic        w_idle;
  logic        w_req;
  logic        w_sel_wr;
  logic [2:0]  w_sel_funct3;
  logic [1:0]  w_sel_addr_lo;
  logic [31:0] w_sel_wdata;
  logic        w_misalign;
  logic [LSU_BE_W-1:0] w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_ext;

  assign w_memop = ex_valid_i & (mem_rd_i | mem_wr_i);
  assign w_idle  = (r_state == LSU_IDLE);
  assign w_req   = (r_state == LSU_REQ);

  // In IDLE the aligner looks at the incoming op to catch misalignment in the
  // same cycle; afterwards it sees only the registered op so the bus is stable.
  assign w_sel_wr      = w_idle ? mem_wr_i      : r_wr;
  assign w_sel_funct3  = w_idle ? funct3_i      : r_funct3;
  assign w_sel_addr_lo = w_idle ? addr_i[1:0]   : r_addr[1:0];
  assign w_sel_wdata   = w_idle ? wdata_i       : r_wdata;

  lsu_align u_align (
    .i_wr       (w_sel_wr),
    .i_funct3   (w_sel_funct3),
    .i_addr_lo  (w_sel_addr_lo),
    .i_wdata    (w_sel_wdata),
    .i_rdata    (bus_rdata_i),
    .o_misalign (w_misalign),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_ext)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= LSU_IDLE;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_memop) begin
            r_wr     <= mem_wr_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_err    <= w_misalign;
            r_state  <= w_misalign ? LSU_DONE : LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (bus_gnt_i)
            r_state <= r_wr ? LSU_DONE : LSU_RESP;
        end
        LSU_RESP: begin
          if (bus_rvalid_i) begin
            r_rdata <= w_rdata_ext;
            r_state <= LSU_DONE;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign stall_o     = rst_n_i & ((w_idle & w_memop) | w_req | (r_state == LSU_RESP));
  assign done_o      = (r_state == LSU_DONE);
  assign misalign_o  = done_o & r_err;
  assign rdata_o     = r_rdata;
  assign bus_req_o   = w_req;
  assign bus_we_o    = w_req & r_wr;
  assign bus_addr_o  = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus_be_o    = w_req ? w_be : 4'b0000;
  assign bus_wdata_o = w_req ? w_wdata : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for lsu: table of single accesses plus hand-written
// wait-state and reset-mid-access sequences.
module tb_lsu;

  typedef struct {
    logic        isRd;
    logic        isWr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        expErr;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exValid, memRd, memWr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign;
  logic [31:0] rdata;
  logic        busReq, busWe, busGnt, busRvalid;
  logic [31:0] busAddr, busWdata, busRdata;
  logic [3:0]  busBe;

  int total = 0;
  int bad = 0;
  logic [31:0] lastRdata = 32'h0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  lsu dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .ex_valid_i   (exValid),
    .mem_rd_i     (memRd),
    .mem_wr_i     (memWr),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .done_o       (done),
    .rdata_o      (rdata),
    .misalign_o   (misalign),
    .bus_req_o    (busReq),
    .bus_we_o     (busWe),
    .bus_addr_o   (busAddr),
    .bus_be_o     (busBe),
    .bus_wdata_o  (busWdata),
    .bus_gnt_i    (busGnt),
    .bus_rvalid_i (busRvalid),
    .bus_rdata_i  (busRdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput($sformatf("%s.done", tag), done, 0);
    checkOutput($sformatf("%s.misalign", tag), misalign, 0);
    checkOutput($sformatf("%s.stall", tag), stall, 0);
    checkOutput($sformatf("%s.busReq", tag), busReq, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int gntDelay, input int rvDelay, input string tag);
    @(negedge clk);
    exValid = 1'b1; memRd = v.isRd; memWr = v.isWr;
    funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    #1;
    checkOutput($sformatf("%s.stallT", tag), stall, 1);
    checkOutput($sformatf("%s.reqT", tag), busReq, 0);
    checkOutput($sformatf("%s.doneT", tag), done, 0);
    if (v.expErr) begin
      @(negedge clk);
      checkOutput($sformatf("%s.errDone", tag), done, 1);
      checkOutput($sformatf("%s.errFlag", tag), misalign, 1);
      checkOutput($sformatf("%s.errReq", tag), busReq, 0);
      checkOutput($sformatf("%s.errStall", tag), stall, 0);
      checkOutput($sformatf("%s.errRdata", tag), rdata, lastRdata);
    end else begin
      for (int i = 0; i <= gntDelay; i++) begin
        @(negedge clk);
        checkOutput($sformatf("%s.req%0d", tag, i), busReq, 1);
        checkOutput($sformatf("%s.stallReq%0d", tag, i), stall, 1);
        checkOutput($sformatf("%s.doneReq%0d", tag, i), done, 0);
        checkOutput($sformatf("%s.we%0d", tag, i), busWe, v.isWr);
        checkOutput($sformatf("%s.addr%0d", tag, i), busAddr, v.expAddr);
        checkOutput($sformatf("%s.be%0d", tag, i), busBe, v.expBe);
        if (v.isWr)
          checkOutput($sformatf("%s.wdata%0d", tag, i), busWdata, v.expWdata);
        busGnt = (i == gntDelay);
      end
      @(negedge clk);
      busGnt = 1'b0;
      if (v.isRd) begin
        for (int i = 0; i <= rvDelay; i++) begin
          checkOutput($sformatf("%s.stallResp%0d", tag, i), stall, 1);
          checkOutput($sformatf("%s.reqResp%0d", tag, i), busReq, 0);
          checkOutput($sformatf("%s.doneResp%0d", tag, i), done, 0);
          busRvalid = (i == rvDelay);
          busRdata  = (i == rvDelay) ? v.rdata : ~v.rdata;
          @(negedge clk);
        end
        busRvalid = 1'b0;
        busRdata  = 32'h0;
      end
      checkOutput($sformatf("%s.done", tag), done, 1);
      checkOutput($sformatf("%s.misalign", tag), misalign, 0);
      checkOutput($sformatf("%s.stallDone", tag), stall, 0);
      checkOutput($sformatf("%s.rdata", tag), rdata, v.isRd ? v.expRdata : lastRdata);
      if (v.isRd) lastRdata = v.expRdata;
    end
    exValid = 1'b0; memRd = 1'b0; memWr = 1'b0;
    @(negedge clk);
    checkIdleQuiet($sformatf("%s.after", tag));
  endtask

  initial begin
    rstN = 1'b0; exValid = 0; memRd = 0; memWr = 0; funct3 = 0;
    addr = 0; wdata = 0; busGnt = 0; busRvalid = 0; busRdata = 0;

    //           rd wr f3      addr          wdata         rdata         err expAddr       be       expWdata      expRdata
    vecs[0]  = '{0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[1]  = '{1, 0, 3'b000, 32'h0000_2001, 32'h0,        32'h1234_8000, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h0000_2001, 32'h0,        32'h1234_8000, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1, 0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_FFFF, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'hFFFF_8001};
    vecs[4]  = '{1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_FFFF, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'h0000_8001};
    vecs[5]  = '{1, 0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{0, 1, 3'b001, 32'h0000_3001, 32'h0000_1234, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{0, 1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0,        0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[8]  = '{0, 1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1, 0, 3'b010, 32'h0000_4004, 32'h0,        32'hCAFE_F00D, 0, 32'h0000_4004, 4'b1111, 32'h0,        32'hCAFE_F00D};
    vecs[10] = '{1, 0, 3'b000, 32'h0000_5000, 32'h0,        32'h0000_007F, 0, 32'h0000_5000, 4'b1111, 32'h0,        32'h0000_007F};
    vecs[11] = '{1, 0, 3'b011, 32'h0000_6000, 32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[12] = '{0, 1, 3'b100, 32'h0000_6000, 32'h0000_0011, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1, 0, 3'b100, 32'h0000_5003, 32'h0,        32'hAB00_0000, 0, 32'h0000_5000, 4'b1111, 32'h0,        32'h0000_00AB};

    #2;
    checkIdleQuiet("reset");
    checkOutput("reset.rdata", rdata, 32'h0);
    checkOutput("reset.busAddr", busAddr, 32'h0);
    checkOutput("reset.busBe", busBe, 32'h0);
    checkOutput("reset.busWdata", busWdata, 32'h0);
    checkOutput("reset.busWe", busWe, 0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // Wait states on grant and on read data
    applyStimulus('{0, 1, 3'b010, 32'h0000_4008, 32'h0102_0304, 32'h0, 0,
                    32'h0000_4008, 4'b1111, 32'h0102_0304, 32'h0}, 3, 0, "swGntWait");
    applyStimulus('{1, 0, 3'b010, 32'h0000_400C, 32'h0, 32'h89AB_CDEF, 0,
                    32'h0000_400C, 4'b1111, 32'h0, 32'h89AB_CDEF}, 0, 4, "lwRvWait");

    // Reset while waiting for read data, then a stray rvalid
    @(negedge clk);
    exValid = 1'b1; memRd = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000;
    @(negedge clk);
    checkOutput("rst.req", busReq, 1);
    busGnt = 1'b1;
    @(negedge clk);
    busGnt = 1'b0;
    checkOutput("rst.stallResp", stall, 1);
    rstN = 1'b0;
    #1;
    checkIdleQuiet("rst.during");
    checkOutput("rst.rdata", rdata, 32'h0);
    checkOutput("rst.busAddr", busAddr, 32'h0);
    exValid = 1'b0; memRd = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    busRvalid = 1'b1; busRdata = 32'h5555_AAAA;
    @(negedge clk);
    busRvalid = 1'b0; busRdata = 32'h0;
    checkIdleQuiet("rst.stray");
    checkOutput("rst.strayRdata", rdata, 32'h0);
    @(negedge clk);
    checkIdleQuiet("rst.final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit forming the memory stage directly downstream of the ALU. It takes the ALU's 32-bit result as the effective address and performs RV32I loads and stores through a single-outstanding request/grant/response data-bus port. It aligns store data into byte lanes, and sign- or zero-extends load data. It stalls the upstream pipeline while an access is in flight and flags misaligned accesses without touching the bus.

## Interface
Parameters: none; widths come from `core_param.v` (`` `RegBus `` = [31:0]).
- clk_i  in  1  core clock; all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low; one clock domain
- ex_valid_i  in  1  instruction present from execute stage
- mem_rd_i  in  1  instruction is a load
- mem_wr_i  in  1  instruction is a store (never both with mem_rd_i)
- funct3_i  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold upstream stages
- done_o  out  1  one-cycle pulse: access finished
- rdata_o  out  32  extended load result, valid when done_o & load
- misalign_o  out  1  one-cycle pulse with done_o: misaligned or illegal funct3; no bus access
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address, bits [1:0] = 00
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-aligned write data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data word

## Operation
- States: IDLE, REQ, RESP, DONE. Reset value: IDLE.
- IDLE:
  - If ex_valid_i & (mem_rd_i|mem_wr_i), capture op, funct3, addr and wdata into registers.
  - If the access is misaligned or illegal, go to DONE with the error flag set.
  - Otherwise go to REQ.
  - With no memory op, stay in IDLE.
- REQ: bus_req_o=1. All bus_* outputs come from the registered op and stay stable until bus_gnt_i.
  - Grant on a store: go to DONE.
  - Grant on a load: go to RESP.
- RESP: wait for bus_rvalid_i. When it arrives, register the extended bus_rdata_i into rdata_o and go to DONE.
- DONE: done_o=1, plus misalign_o if the error flag is set. Go to IDLE unconditionally. Inputs are ignored in this cycle, because the held instruction is still presented.
- Misalignment: H/HU with addr[0]=1; W with addr[1:0]≠00. Illegal funct3 (load 011/110/111, store ≥011) is also flagged.
- Store lanes:
  - SB: be=0001<<addr[1:0]; wdata = byte replicated 4×.
  - SH: be=0011<<{addr[1],0}; wdata = halfword replicated 2×.
  - SW: be=1111.
- Loads: bus_be_o=1111. Select the byte/half by addr[1:0]. Sign-extend for B/H; zero-extend for BU/HU.
- bus_rvalid_i outside RESP is ignored. bus_gnt_i outside REQ is ignored.

## Timing
- stall_o = (IDLE & ex_valid_i & (mem_rd_i|mem_wr_i)) | REQ | RESP. It is combinational, so the stall holds the stage in the same cycle the op is first seen.
- With the op seen at cycle T and immediate grant:
  - store: done_o at T+2.
  - load with rvalid at T+2: done_o at T+3.
  - misaligned: done_o at T+1 and no bus_req_o.
- Grant and rvalid wait states extend REQ and RESP without limit; stall_o stays high throughout.
- Reset values: state IDLE; bus_req_o, bus_we_o, done_o, misalign_o, stall_o = 0; bus_addr_o, bus_be_o, bus_wdata_o, rdata_o = `` `ZeroWord `` / 0.
- Reset mid-access:
  - bus_req_o drops immediately.
  - A late bus_rvalid_i is dropped, since the unit is in IDLE.
- rdata_o holds its value until the next load completes.

## Structure
- Add to `core_param.v`:
  - LSU state encodings (2 bits).
  - funct3 codes (`` `LSU_B ``, `` `LSU_H ``, `` `LSU_W ``, `` `LSU_BU ``, `` `LSU_HU ``).
  - Byte-enable width define.
- Top `lsu` contains the FSM and the operand registers.
- One combinational sub-module, `lsu_align`, is natural. It holds the misalignment detect, store lane/byte-enable generation, and load extraction/extension, and can be unit-tested standalone.

## Test plan
- SB addr=0x1003, wdata=0x000000A5, gnt on first REQ cycle -> bus_addr_o=0x1000, be=1000, wdata=0xA5A5A5A5, done_o at T+2, stall_o high T..T+1.
- LB addr=0x2001, rdata word=0x12348000 -> rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH addr=0x2002, rdata=0x8001FFFF -> 0xFFFF8001. LHU -> 0x00008001.
- LW addr=0x3002 -> no bus_req_o, done_o & misalign_o at T+1. SH addr=0x3001 gives the same result.
- SW with gnt delayed 3 cycles and LW with rvalid delayed 4 cycles -> bus_* outputs stable through the wait, stall_o high throughout, done_o a single cycle.
- rst_n_i asserted in RESP, then a stray rvalid -> all outputs 0 immediately, state IDLE, rdata_o unchanged at 0, no done_o.
